network_result_voter: RTL and testbench



---
 rtl/network_result_voter.sv | 177 +++++++++++++++++
 tb/tb_network_result_voter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/network_result_voter.sv
// Samples the comparator-tree class code a fixed latency after each frame start, decodes it and debounces it.
// Optional feature macro: RESULT_HIST_EN adds a per-class histogram of confirmed words (hist_sel/hist_count).
module network_result_voter #(
  parameter int unsigned LATENCY       = 16,
  parameter int unsigned NUM_CLASSES   = 20,
  parameter int unsigned CONFIRM_COUNT = 3,
  localparam int unsigned IDX_W  = 5,
  localparam int unsigned RUN_W  = 4,
  localparam int unsigned HIST_W = 8,
  localparam int unsigned CNT_W  = $clog2(LATENCY + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NUM_CLASSES-1:0] network_encode_output,
`ifdef RESULT_HIST_EN
  input  logic [IDX_W-1:0]       hist_sel,
  output logic [HIST_W-1:0]      hist_count,
`endif
  output logic                   busy,
  output logic                   frame_valid,
  output logic [IDX_W-1:0]       frame_index,
  output logic                   onehot_error,
  output logic                   overrun,
  output logic                   word_confirmed,
  output logic [IDX_W-1:0]       word_index,
  output logic [RUN_W-1:0]       run_count
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [RUN_W-1:0] CONFIRM_C = RUN_W'(CONFIRM_COUNT);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, EVAL} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic                   overrun_d;
  logic [NUM_CLASSES-1:0] cap_q;
  logic [IDX_W-1:0]       last_index_q;
  logic                   last_valid_q;

  logic                   code_onehot;
  logic [IDX_W-1:0]       code_idx;
  logic                   same_run;
  logic [RUN_W-1:0]       run_next;
  logic                   confirm;

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Next state: SAMPLE is entered as the counter reaches 0, so the capture edge is start edge + LATENCY
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    overrun_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (start) begin
          overrun_d = 1'b1;
          cnt_d     = WAIT_LOAD;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SAMPLE: begin
        state_d = EVAL;
        if (start) begin
          overrun_d = 1'b1;
          pend_d    = 1'b1;
        end
      end
      EVAL: begin
        if (start || pend_q) begin
          state_d   = WAIT;
          cnt_d     = WAIT_LOAD;
          pend_d    = 1'b0;
          overrun_d = start;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-hot decode and run-length evaluation of the captured code
  always_comb begin
    code_onehot = (cap_q != '0) && ((cap_q & (cap_q - NUM_CLASSES'(1))) == '0);
    code_idx    = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (cap_q[i]) code_idx = IDX_W'(i);
    end
    same_run = last_valid_q && (code_idx == last_index_q);
    if (!same_run)                  run_next = RUN_W'(1);
    else if (run_count == CONFIRM_C) run_next = CONFIRM_C;
    else                             run_next = run_count + RUN_W'(1);
    confirm = (run_next == CONFIRM_C) && !(same_run && (run_count == CONFIRM_C));
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cap_q          <= '0;
      busy           <= 1'b0;
      frame_valid    <= 1'b0;
      frame_index    <= '0;
      onehot_error   <= 1'b0;
      overrun        <= 1'b0;
      word_confirmed <= 1'b0;
      word_index     <= '0;
      run_count      <= '0;
      last_index_q   <= '0;
      last_valid_q   <= 1'b0;
    end else begin
      busy           <= (state_d != IDLE);
      overrun        <= overrun_d;
      frame_valid    <= 1'b0;
      onehot_error   <= 1'b0;
      word_confirmed <= 1'b0;
      if (state_q == SAMPLE) cap_q <= network_encode_output;
      if (state_q == EVAL) begin
        frame_valid <= 1'b1;
        if (!code_onehot) begin
          onehot_error <= 1'b1;
          run_count    <= '0;
          last_valid_q <= 1'b0;
        end else begin
          frame_index  <= code_idx;
          run_count    <= run_next;
          last_index_q <= code_idx;
          last_valid_q <= 1'b1;
          if (confirm) begin
            word_confirmed <= 1'b1;
            word_index     <= code_idx;
          end
        end
      end
    end
  end

`ifdef RESULT_HIST_EN
  logic [HIST_W-1:0] hist_q [NUM_CLASSES];

  // Saturating per-class confirmation counters with a registered read port
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < NUM_CLASSES; c++) hist_q[c] <= '0;
      hist_count <= '0;
    end else begin
      if ((state_q == EVAL) && code_onehot && confirm && (hist_q[code_idx] != '1))
        hist_q[code_idx] <= hist_q[code_idx] + HIST_W'(1);
      hist_count <= (32'(hist_sel) < NUM_CLASSES) ? hist_q[hist_sel] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_network_result_voter.sv
// Directed self-checking bench for network_result_voter (default parameters).
module tb_network_result_voter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [19:0] network_encode_output;
  logic        busy, frame_valid, onehot_error, overrun, word_confirmed;
  logic [4:0]  frame_index, word_index;
  logic [3:0]  run_count;
`ifdef RESULT_HIST_EN
  logic [4:0]  hist_sel;
  logic [7:0]  hist_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  network_result_voter dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .start                 (start),
    .network_encode_output (network_encode_output),
`ifdef RESULT_HIST_EN
    .hist_sel              (hist_sel),
    .hist_count            (hist_count),
`endif
    .busy                  (busy),
    .frame_valid           (frame_valid),
    .frame_index           (frame_index),
    .onehot_error          (onehot_error),
    .overrun               (overrun),
    .word_confirmed        (word_confirmed),
    .word_index            (word_index),
    .run_count             (run_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated frame: start pulse, then a 20-cycle observation window
  task automatic run_frame(input string tag, input logic [19:0] code, input logic [4:0] e_idx,
                           input logic e_err, input logic [3:0] e_run, input logic e_conf,
                           input logic [4:0] e_word);
    int busy_n, fv_n, wc_n;
    network_encode_output = code;
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_n = int'(busy);
    fv_n = 0;
    wc_n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      busy_n += int'(busy);
      fv_n   += int'(frame_valid);
      wc_n   += int'(word_confirmed);
      if (k == 16) chk({tag, ".fv_early"}, 32'(frame_valid), 32'd0);
      if (k == 17) begin
        chk({tag, ".fv"},   32'(frame_valid),    32'd1);
        chk({tag, ".idx"},  32'(frame_index),    32'(e_idx));
        chk({tag, ".err"},  32'(onehot_error),   32'(e_err));
        chk({tag, ".run"},  32'(run_count),      32'(e_run));
        chk({tag, ".conf"}, 32'(word_confirmed), 32'(e_conf));
        chk({tag, ".word"}, 32'(word_index),     32'(e_word));
      end
    end
    chk({tag, ".busy_cycles"}, 32'(busy_n), 32'd17);
    chk({tag, ".fv_count"},    32'(fv_n),   32'd1);
    chk({tag, ".conf_count"},  32'(wc_n),   32'(e_conf));
  endtask

  initial begin
    int fv_n, wc_n, err_n;
    rst_n = 1'b1;
    start = 1'b0;
    network_encode_output = '0;
`ifdef RESULT_HIST_EN
    hist_sel = '0;
`endif
    repeat (3) tick();
    rst_n = 1'b0;

    chk("rst.busy", 32'(busy), 0);
    chk("rst.fv", 32'(frame_valid), 0);
    chk("rst.idx", 32'(frame_index), 0);
    chk("rst.err", 32'(onehot_error), 0);
    chk("rst.overrun", 32'(overrun), 0);
    chk("rst.conf", 32'(word_confirmed), 0);
    chk("rst.word", 32'(word_index), 0);
    chk("rst.run", 32'(run_count), 0);
    repeat (6) tick();

    run_frame("t1", 20'h00004, 5'd2, 1'b0, 4'd1, 1'b0, 5'd0);

    run_frame("t2a", 20'h80000, 5'd19, 1'b0, 4'd1, 1'b0, 5'd0);
    run_frame("t2b", 20'h80000, 5'd19, 1'b0, 4'd2, 1'b0, 5'd0);
    run_frame("t2c", 20'h80000, 5'd19, 1'b0, 4'd3, 1'b1, 5'd19);
    run_frame("t2d", 20'h80000, 5'd19, 1'b0, 4'd3, 1'b0, 5'd19);

    run_frame("t3a", 20'h00001, 5'd0, 1'b0, 4'd1, 1'b0, 5'd19);
    run_frame("t3b", 20'h00001, 5'd0, 1'b0, 4'd2, 1'b0, 5'd19);
    run_frame("t3c", 20'h00000, 5'd0, 1'b1, 4'd0, 1'b0, 5'd19);
    run_frame("t3d", 20'h00001, 5'd0, 1'b0, 4'd1, 1'b0, 5'd19);

    run_frame("t4", 20'h00011, 5'd0, 1'b1, 4'd0, 1'b0, 5'd19);

    run_frame("t5a", 20'h00001, 5'd0, 1'b0, 4'd1, 1'b0, 5'd19);
    run_frame("t5b", 20'h00001, 5'd0, 1'b0, 4'd2, 1'b0, 5'd19);
    run_frame("t5c", 20'h00001, 5'd0, 1'b0, 4'd3, 1'b1, 5'd0);

    // Second start 5 cycles into WAIT restarts the latency window
    network_encode_output = 20'h00008;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6.overrun_first", 32'(overrun), 0);
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6.overrun", 32'(overrun), 1);
    fv_n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      fv_n += int'(frame_valid);
      if (k == 1) chk("t6.overrun_clear", 32'(overrun), 0);
      if (k == 12) chk("t6.fv_stale", 32'(frame_valid), 0);
      if (k == 17) begin
        chk("t6.fv", 32'(frame_valid), 1);
        chk("t6.idx", 32'(frame_index), 3);
        chk("t6.run", 32'(run_count), 1);
      end
    end
    chk("t6.fv_count", 32'(fv_n), 1);

    // Code is valid only in the cycle before the capture edge
    network_encode_output = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      network_encode_output = (k == 16) ? 20'h00040 : 20'h00000;
      tick();
      if (k == 17) begin
        chk("t7.fv", 32'(frame_valid), 1);
        chk("t7.err", 32'(onehot_error), 0);
        chk("t7.idx", 32'(frame_index), 6);
        chk("t7.run", 32'(run_count), 1);
      end
    end

    // Start arriving during SAMPLE is deferred to the end of the current frame
    network_encode_output = 20'h00040;
    start = 1'b1;
    tick();
    start = 1'b0;
    fv_n = 0;
    for (int k = 1; k <= 36; k++) begin
      start = (k == 16);
      tick();
      start = 1'b0;
      fv_n += int'(frame_valid);
      if (k == 16) chk("t8.overrun", 32'(overrun), 1);
      if (k == 17) begin
        chk("t8.fv1", 32'(frame_valid), 1);
        chk("t8.run1", 32'(run_count), 2);
        chk("t8.conf1", 32'(word_confirmed), 0);
      end
      if (k == 18) chk("t8.busy_chain", 32'(busy), 1);
      if (k == 34) begin
        chk("t8.fv2", 32'(frame_valid), 1);
        chk("t8.run2", 32'(run_count), 3);
        chk("t8.conf2", 32'(word_confirmed), 1);
        chk("t8.word2", 32'(word_index), 6);
      end
    end
    chk("t8.fv_count", 32'(fv_n), 2);

    // Reset mid-frame abandons the pending sample
    network_encode_output = 20'h00004;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    chk("t9.busy", 32'(busy), 0);
    chk("t9.run", 32'(run_count), 0);
    chk("t9.word", 32'(word_index), 0);
    chk("t9.idx", 32'(frame_index), 0);
    fv_n = 0;
    wc_n = 0;
    err_n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      fv_n  += int'(frame_valid);
      wc_n  += int'(word_confirmed);
      err_n += int'(onehot_error) + int'(overrun);
    end
    chk("t9.fv_none", 32'(fv_n), 0);
    chk("t9.conf_none", 32'(wc_n), 0);
    chk("t9.pulse_none", 32'(err_n), 0);

`ifdef RESULT_HIST_EN
    run_frame("h1a", 20'h00020, 5'd5, 1'b0, 4'd1, 1'b0, 5'd0);
    run_frame("h1b", 20'h00020, 5'd5, 1'b0, 4'd2, 1'b0, 5'd0);
    run_frame("h1c", 20'h00020, 5'd5, 1'b0, 4'd3, 1'b1, 5'd5);
    run_frame("h2a", 20'h00040, 5'd6, 1'b0, 4'd1, 1'b0, 5'd5);
    run_frame("h2b", 20'h00040, 5'd6, 1'b0, 4'd2, 1'b0, 5'd5);
    run_frame("h2c", 20'h00040, 5'd6, 1'b0, 4'd3, 1'b1, 5'd6);
    run_frame("h3a", 20'h00020, 5'd5, 1'b0, 4'd1, 1'b0, 5'd6);
    run_frame("h3b", 20'h00020, 5'd5, 1'b0, 4'd2, 1'b0, 5'd6);
    run_frame("h3c", 20'h00020, 5'd5, 1'b0, 4'd3, 1'b1, 5'd5);
    hist_sel = 5'd5;
    tick();
    chk("hist.sel5", 32'(hist_count), 2);
    hist_sel = 5'd6;
    tick();
    chk("hist.sel6", 32'(hist_count), 1);
    hist_sel = 5'd25;
    tick();
    chk("hist.sel25", 32'(hist_count), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
